// File: rtl/dmem_bridge.sv
// dmem_bridge: CortexM0 data port to synchronous SRAM port 2 bridge with alignment, byte enables and fault detection
module dmem_bridge #(
  parameter int AW = 12
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          DREQ,
  input  logic [31:0]   DADDR,
  input  logic          DRW,
  input  logic [1:0]    DSIZE,
  input  logic          DSIGNED,
  input  logic [31:0]   DOUT,
  output logic [31:0]   DIN,
  output logic          DREADY,
  output logic          DERR,
  output logic          CSN,
  output logic [AW-1:0] ADDR,
  output logic          WE,
  output logic [3:0]    BE,
  output logic [31:0]   DI,
  input  logic [31:0]   DO
);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
  state_t      state;
  logic [1:0]  a_q, size_q;
  logic        sgn_q, rd_q, fault;
  logic [3:0]  be_w;
  logic [31:0] di_w;
  logic [7:0]  lane;
  logic [15:0] half;
  // Request decode on the live inputs so the strobes can be registered at the capture edge;
  // DIN is steered straight from the SRAM output register during RDATA to keep the 2-cycle read latency
  always_comb begin
    fault = (DSIZE == 2'b11) | (DSIZE == 2'b01 & DADDR[0]) | (DSIZE == 2'b10 & |DADDR[1:0]) | (|DADDR[31:AW+2]);
    be_w  = DSIZE == 2'b00 ? 4'b0001 << DADDR[1:0] : DSIZE == 2'b01 ? (DADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    di_w  = DSIZE == 2'b00 ? {4{DOUT[7:0]}} : DSIZE == 2'b01 ? {2{DOUT[15:0]}} : DOUT;
    lane  = DO[{a_q, 3'b000} +: 8];
    half  = a_q[1] ? DO[31:16] : DO[15:0];
    DIN   = state != RDATA ? 32'h0 :
            size_q == 2'b00 ? {{24{sgn_q & lane[7]}}, lane} :
            size_q == 2'b01 ? {{16{sgn_q & half[15]}}, half} : DO;
  end
  // Request FSM with registered SRAM strobes and completion pulses
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      a_q    <= '0;
      size_q <= '0;
      sgn_q  <= 1'b0;
      rd_q   <= 1'b0;
      CSN    <= 1'b1;
      WE     <= 1'b0;
      BE     <= '0;
      ADDR   <= '0;
      DI     <= '0;
      DREADY <= 1'b0;
      DERR   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (DREQ) begin
          state  <= ACCESS;
          a_q    <= DADDR[1:0];
          size_q <= DSIZE;
          sgn_q  <= DSIGNED;
          rd_q   <= !DRW && !fault;
          CSN    <= fault;
          WE     <= DRW && !fault;
          BE     <= fault ? 4'b0000 : DRW ? be_w : 4'b1111;
          ADDR   <= DADDR[AW+1:2];
          DI     <= DRW && !fault ? di_w : DI;
          DREADY <= DRW || fault;
          DERR   <= fault;
        end
        ACCESS: begin
          state  <= rd_q ? RDATA : IDLE;
          CSN    <= 1'b1;
          WE     <= 1'b0;
          BE     <= '0;
          DREADY <= rd_q;
          DERR   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          DREADY <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Data-memory bridge between the CortexM0 data port (DREQ/DADDR/DRW/DSIZE/DOUT/DIN) and port 2 of the synchronous SRAM.
- Registers each request and generates the SRAM chip select, word address, write enable, byte enables and lane-replicated write data.
- Aligns and zero/sign-extends read data from the SRAM, which has one cycle of read latency.
- Returns a one-cycle DREADY, or DERR for misaligned or out-of-range accesses.
- Replaces the combinational DBE decode that currently sits in the top level.

Parameters:
- AW, 12, SRAM word-address width (SRAM spans 2^(AW+2) bytes).

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- DREQ  in  1  core access request; held until DREADY.
- DADDR  in  32  byte address.
- DRW  in  1  1 = write, 0 = read.
- DSIZE  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- DSIGNED  in  1  1 = sign-extend a byte/half load.
- DOUT  in  32  core write data, right-justified.
- DIN  out  32  read data to core, valid while DREADY=1.
- DREADY  out  1  one-cycle completion pulse.
- DERR  out  1  one-cycle fault, coincident with DREADY.
- CSN  out  1  SRAM chip select, active low.
- ADDR  out  AW  SRAM word address.
- WE  out  1  SRAM write enable.
- BE  out  4  SRAM byte enables.
- DI  out  32  SRAM write data.
- DO  in  32  SRAM read data, valid the cycle after a read strobe.

Behaviour:
- Clock and reset:
  - One clock domain (CLK); RESET_N is asynchronous and active low.
  - Reset forces state IDLE and clears all captured registers.
  - Reset values: CSN=1, WE=0, BE=0, ADDR=0, DI=0, DIN=0, DREADY=0, DERR=0.
  - A reset asserted mid-access aborts it: no DREADY is issued, and any SRAM strobe is removed immediately (asynchronously).
- FSM states: IDLE, ACCESS, RDATA.
- IDLE:
  - If DREQ=1, capture DADDR, DRW, DSIZE, DSIGNED and DOUT; go to ACCESS. Otherwise stay.
  - CSN=1 in IDLE.
- Fault check (on the captured request):
  - DSIZE=11.
  - DSIZE=01 with addr[0]=1.
  - DSIZE=10 with addr[1:0]!=0.
  - addr[31:AW+2]!=0.
- ACCESS (cycle N+1, where N is the capture cycle):
  - Fault: CSN=1, WE=0, DREADY=1, DERR=1, DIN=0; go to IDLE.
  - Write: CSN=0, WE=1, ADDR=addr[AW+1:2], BE and DI per the rules below, DREADY=1; go to IDLE.
  - Read: CSN=0, WE=0, BE=1111, ADDR=addr[AW+1:2]; go to RDATA.
- RDATA (cycle N+2):
  - CSN=1.
  - DIN = aligned and extended DO.
  - DREADY=1; go to IDLE.
- Latency: write or fault completes 1 cycle after capture; read completes 2 cycles after capture.
- BE (write):
  - Byte: 0001 / 0010 / 0100 / 1000 for addr[1:0] = 0 / 1 / 2 / 3.
  - Half: 0011 for addr[1]=0, 1100 for addr[1]=1.
  - Word: 1111.
- DI (write lane replication):
  - Byte: {4{DOUT[7:0]}}.
  - Half: {2{DOUT[15:0]}}.
  - Word: DOUT.
- DIN (read):
  - Byte: lane DO[8*a+7:8*a], where a = addr[1:0].
  - Half: DO[31:16] if addr[1]=1, else DO[15:0].
  - Extension: sign-extend when DSIGNED=1, zero-extend otherwise.
  - Word: DO unchanged; DSIGNED is ignored.
- Outputs are registered.
  - DREADY, DERR and DIN are held for exactly one cycle, then return to 0.
- Handshake:
  - Request inputs are sampled only in IDLE, so changes to DADDR, DOUT, etc. during ACCESS/RDATA are ignored.
  - DREQ still high in the IDLE cycle after DREADY is treated as a new request.
  - Back-to-back throughput: one write per 2 cycles, one read per 3 cycles.
- DREQ=0 in IDLE: no SRAM activity; CSN stays 1.

Test Plan:
- Reset: hold RESET_N=0 with DREQ=1 -> CSN=1, WE=0, DREADY=0, DIN=0. Release RESET_N -> capture on the next edge, ACCESS one cycle later.
- Byte write: DADDR=0x0000_0103, DSIZE=00, DOUT=0x0000_00A5 -> at N+1: CSN=0, WE=1, ADDR=0x040, BE=1000, DI=0xA5A5A5A5, DREADY=1, DERR=0.
- Signed half read: DADDR=0x0000_0202, DSIZE=01, DSIGNED=1, SRAM DO=0x8001_7FFF -> at N+2: DIN=0xFFFF_8001, DREADY=1. Repeat with DSIGNED=0 -> DIN=0x0000_8001.
- Word write then word read: DADDR=0x210, DOUT=0xDEAD_BEEF -> BE=1111. Read-back request issued the cycle after DREADY -> DIN=0xDEAD_BEEF at capture+2.
- Faults (each case):
  - DSIZE=10, DADDR=0x6 -> DERR=1, DREADY=1 at N+1, CSN stays 1, DIN=0.
  - DADDR=0x0001_0000 -> same fault response.
  - DSIZE=11 -> same fault response.
- Reset mid-read: assert RESET_N=0 during RDATA -> DREADY never pulses, state returns to IDLE. The next request completes normally with 2-cycle latency.
